// File: rtl/alu_shift_sequencer.sv
// Iterative shift/rotate sequencer: drives the shared ALU with one 1-bit step per
// clock, keeping the working operand, flags and remaining count between steps.
module alu_shift_sequencer #(
  parameter int MAX_COUNT_BITS  = 5,
  parameter int MC_ALUOP_T_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [2:0]                 shift_kind,
  input  logic                       is_8_bit,
  input  logic [15:0]                operand,
  input  logic [MAX_COUNT_BITS-1:0]  count,
  input  logic [15:0]                flags_in,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                result,
  output logic [15:0]                flags_result,
  output logic [15:0]                alu_a,
  output logic [15:0]                alu_b,
  output logic [MC_ALUOP_T_BITS-1:0] alu_op,
  output logic                       alu_is_8_bit,
  output logic [15:0]                alu_flags_in,
  input  logic [15:0]                alu_out,
  input  logic [15:0]                alu_flags_out
);

  localparam logic [MC_ALUOP_T_BITS-1:0] ALUOP_SELA = MC_ALUOP_T_BITS'(0);
  localparam logic [MC_ALUOP_T_BITS-1:0] ALUOP_ROL  = MC_ALUOP_T_BITS'(1);
  localparam logic [MC_ALUOP_T_BITS-1:0] ALUOP_ROR  = MC_ALUOP_T_BITS'(2);
  localparam logic [MC_ALUOP_T_BITS-1:0] ALUOP_RCL  = MC_ALUOP_T_BITS'(3);
  localparam logic [MC_ALUOP_T_BITS-1:0] ALUOP_RCR  = MC_ALUOP_T_BITS'(4);
  localparam logic [MC_ALUOP_T_BITS-1:0] ALUOP_SHL  = MC_ALUOP_T_BITS'(5);
  localparam logic [MC_ALUOP_T_BITS-1:0] ALUOP_SHR  = MC_ALUOP_T_BITS'(6);
  localparam logic [MC_ALUOP_T_BITS-1:0] ALUOP_SAR  = MC_ALUOP_T_BITS'(7);
  localparam logic [MAX_COUNT_BITS-1:0]  COUNT_ZERO = '0;
  localparam logic [MAX_COUNT_BITS-1:0]  COUNT_ONE  = MAX_COUNT_BITS'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [15:0]                 work_val_q, work_val_d;
  logic [15:0]                 work_flags_q, work_flags_d;
  logic [MAX_COUNT_BITS-1:0]   remaining_q, remaining_d;
  logic [2:0]                  kind_q, kind_d;
  logic                        is_8_bit_q, is_8_bit_d;
  logic [15:0]                 result_q, result_d;
  logic [15:0]                 flags_result_q, flags_result_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      work_val_q     <= '0;
      work_flags_q   <= '0;
      remaining_q    <= '0;
      kind_q         <= '0;
      is_8_bit_q     <= 1'b0;
      result_q       <= '0;
      flags_result_q <= '0;
    end else begin
      state_q        <= state_d;
      work_val_q     <= work_val_d;
      work_flags_q   <= work_flags_d;
      remaining_q    <= remaining_d;
      kind_q         <= kind_d;
      is_8_bit_q     <= is_8_bit_d;
      result_q       <= result_d;
      flags_result_q <= flags_result_d;
    end
  end

  // Abort has priority over both a new start and the final step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !abort) state_d = (count == COUNT_ZERO) ? DONE : RUN;
      RUN: begin
        if (abort)                         state_d = IDLE;
        else if (remaining_q == COUNT_ONE) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are loaded on entry to DONE; a zero count bypasses the ALU entirely.
  always_comb begin
    work_val_d     = work_val_q;
    work_flags_d   = work_flags_q;
    remaining_d    = remaining_q;
    kind_d         = kind_q;
    is_8_bit_d     = is_8_bit_q;
    result_d       = result_q;
    flags_result_d = flags_result_q;
    if (state_q == IDLE && start && !abort) begin
      work_val_d   = operand;
      work_flags_d = flags_in;
      remaining_d  = count;
      kind_d       = shift_kind;
      is_8_bit_d   = is_8_bit;
      if (count == COUNT_ZERO) begin
        result_d       = operand;
        flags_result_d = flags_in;
      end
    end else if (state_q == RUN && !abort) begin
      work_val_d   = alu_out;
      work_flags_d = alu_flags_out;
      remaining_d  = remaining_q - COUNT_ONE;
      if (remaining_q == COUNT_ONE) begin
        result_d       = alu_out;
        flags_result_d = alu_flags_out;
      end
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == DONE) && !abort;
    result       = result_q;
    flags_result = flags_result_q;
    alu_a        = work_val_q;
    alu_flags_in = work_flags_q;
    alu_is_8_bit = is_8_bit_q;
    alu_b        = (state_q == RUN) ? 16'h0001 : 16'h0000;
    alu_op       = ALUOP_SELA;
    if (state_q == RUN) begin
      case (kind_q)
        3'd0:    alu_op = ALUOP_ROL;
        3'd1:    alu_op = ALUOP_ROR;
        3'd2:    alu_op = ALUOP_RCL;
        3'd3:    alu_op = ALUOP_RCR;
        3'd5:    alu_op = ALUOP_SHR;
        3'd6:    alu_op = ALUOP_SAR;
        default: alu_op = ALUOP_SHL;
      endcase
    end
  end

endmodule
